// File: rtl/arb_rr_hold.sv
// N-way round-robin arbiter with grant hold: the owner keeps the grant while its request stays high.
// Optional forced hand-over after MAX_HOLD cycles is enabled by defining ARB_RR_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no owner, gnt == 0, hold_cnt == 0
// ST_OWNED | one requester owns the resource, gnt one-hot, hold_cnt >= 1
module arb_rr_hold #(
  parameter int N        = 4,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic [7:0]     hold_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("arb_rr_hold: N must be in 2..16");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb_rr_hold: MAX_HOLD must be in 2..255");
  end

  logic [0:0]     state;
  logic [IDW-1:0] ptr;

  logic [N-1:0]   cand;
  logic           found;
  logic           hi_found;
  logic [IDW-1:0] hi_id;
  logic [IDW-1:0] lo_id;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] win_next;
  logic [N-1:0]   win_oh;
  logic           release_own;
  logic           revoke;

  // The current owner is masked out, so on a timeout revoke it cannot win again.
  always_comb begin
    cand     = req & ~gnt;
    found    = |cand;
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_id = IDW'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    win_id   = hi_found ? hi_id : lo_id;
    win_next = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
    win_oh   = {{(N-1){1'b0}}, 1'b1} << win_id;
  end

  assign release_own = ~|(req & gnt);

`ifdef ARB_RR_TIMEOUT_EN
  assign revoke = (hold_cnt >= 8'(MAX_HOLD)) && found;
`else
  assign revoke = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      ptr      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state    <= ST_OWNED;
            gnt      <= win_oh;
            gnt_id   <= win_id;
            hold_cnt <= 8'd1;
            ptr      <= win_next;
          end
        end
        ST_OWNED: begin
          if (release_own || revoke) begin
            if (found) begin
              gnt      <= win_oh;
              gnt_id   <= win_id;
              hold_cnt <= 8'd1;
              ptr      <= win_next;
            end else begin
              state    <= ST_IDLE;
              gnt      <= '0;
              gnt_id   <= '0;
              hold_cnt <= '0;
            end
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          gnt      <= '0;
          gnt_id   <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_arb_rr_hold.sv
// Self-checking bench for arb_rr_hold (N=4): vector table plus hand-written timeout and
// saturation sequences, expected results queued at drive time and compared after each edge.
module tb_arb_rr_hold;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic [7:0]     hold_cnt;

  arb_rr_hold #(.N(N), .IDW(IDW), .MAX_HOLD(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] q;
    logic [3:0] g;
    logic [7:0] h;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic [7:0] hold;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [7:0] h);
    vec_t v;
    v.r = r; v.q = q; v.g = g; v.h = h;
    vecs.push_back(v);
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) id = 2'(i);
    return id;
  endfunction

  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] g,
                      input logic [7:0] h, input string nm);
    exp_t e;
    rst = r;
    req = q;
    e.gnt = g; e.id = enc(g); e.busy = |g; e.hold = h; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      if (gnt === e.gnt && gnt_id === e.id && busy === e.busy && hold_cnt === e.hold)
        n_pass++;
      else
        $display("FAIL %s #%0d: got gnt=%b id=%0d busy=%b hold=%0d, want gnt=%b id=%0d busy=%b hold=%0d",
                 e.name, n_checks, gnt, gnt_id, busy, hold_cnt, e.gnt, e.id, e.busy, e.hold);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;

    // reset then idle
    add(1, 4'b1010, 4'b0000, 0); add(1, 4'b1010, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 0); add(0, 4'b0000, 4'b0000, 0);
    // single request held five cycles
    add(0, 4'b0100, 4'b0100, 1); add(0, 4'b0100, 4'b0100, 2); add(0, 4'b0100, 4'b0100, 3);
    add(0, 4'b0100, 4'b0100, 4); add(0, 4'b0100, 4'b0100, 5); add(0, 4'b0000, 4'b0000, 0);
    // simultaneous requests from reset, each owner drops after three cycles
    add(1, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 4'b0001, 1); add(0, 4'b1111, 4'b0001, 2); add(0, 4'b1111, 4'b0001, 3);
    add(0, 4'b1110, 4'b0010, 1); add(0, 4'b1111, 4'b0010, 2); add(0, 4'b1111, 4'b0010, 3);
    add(0, 4'b1101, 4'b0100, 1); add(0, 4'b1111, 4'b0100, 2); add(0, 4'b1111, 4'b0100, 3);
    add(0, 4'b1011, 4'b1000, 1); add(0, 4'b1111, 4'b1000, 2); add(0, 4'b1111, 4'b1000, 3);
    add(0, 4'b0111, 4'b0001, 1);
    // hand-overs including search wrap from ptr=3 to requester 0
    add(0, 4'b1000, 4'b1000, 1); add(0, 4'b1001, 4'b1000, 2); add(0, 4'b0001, 4'b0001, 1);
    add(0, 4'b0000, 4'b0000, 0); add(0, 4'b0100, 4'b0100, 1); add(0, 4'b0001, 4'b0001, 1);
    add(0, 4'b1001, 4'b0001, 2); add(0, 4'b1000, 4'b1000, 1); add(0, 4'b1001, 4'b1000, 2);
    add(0, 4'b0001, 4'b0001, 1); add(0, 4'b0000, 4'b0000, 0);
    // reset mid-grant, ptr returns to 0
    add(0, 4'b0010, 4'b0010, 1); add(0, 4'b0110, 4'b0010, 2); add(0, 4'b0110, 4'b0010, 3);
    add(0, 4'b0110, 4'b0010, 4); add(1, 4'b0110, 4'b0000, 0); add(0, 4'b0110, 4'b0010, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // all requesting from idle with ptr=2
    add(0, 4'b1111, 4'b0100, 1); add(0, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].r, vecs[i].q, vecs[i].g, vecs[i].h, "vec");

    // long hold with a competing request raised at hold_cnt=3
    step(1, 4'b0000, 4'b0000, 0, "to_rst");
    step(0, 4'b0001, 4'b0001, 1, "to_own");
    step(0, 4'b0001, 4'b0001, 2, "to_own");
    step(0, 4'b0001, 4'b0001, 3, "to_own");
    for (int k = 4; k <= 8; k++)
      step(0, 4'b0101, 4'b0001, 8'(k), "to_hold");
`ifdef ARB_RR_TIMEOUT_EN
    step(0, 4'b0101, 4'b0100, 1, "to_revoke");
    step(0, 4'b0101, 4'b0100, 2, "to_newown");
    step(0, 4'b0001, 4'b0001, 1, "to_regrant");
`else
    step(0, 4'b0101, 4'b0001, 9, "to_nolock");
    step(0, 4'b0101, 4'b0001, 10, "to_nolock");
    step(0, 4'b0100, 4'b0100, 1, "to_release");
`endif

    // hold_cnt saturation
    step(1, 4'b0000, 4'b0000, 0, "sat_rst");
    for (int k = 1; k <= 260; k++)
      step(0, 4'b0001, 4'b0001, 8'((k > 255) ? 255 : k), "sat");
    step(0, 4'b0000, 4'b0000, 0, "sat_drop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1);
  end

endmodule
